// File: rtl/dtw_core_pkg.sv
// Shared definitions for the DTW core: run-control FSM encodings and
// the memory-port mode select shared between the loader and readback.
package dtw_core_pkg;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] DUMP = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic MODE_DTW_READ = 1'b0;
   localparam logic MODE_LOAD_REF = 1'b1;

endpackage

// File: rtl/dtw_core_ref_skid.sv
// Two-entry FIFO that absorbs destination backpressure; the head word
// is held in a register so it can drive the FIFO data port directly.
module dtw_core_ref_skid #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         clear,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] head,
   output logic [1:0]   occ
);

   logic [W-1:0] tail;

   always_ff @(posedge clk) begin
      if (clear) begin
         occ  <= 2'd0;
         head <= '0;
         tail <= '0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (occ == 2'd0) head <= din;
               else             tail <= din;
               occ <= occ + 2'd1;
            end
            2'b01: begin
               head <= tail;
               occ  <= occ - 2'd1;
            end
            // occupancy unchanged; the new word lands behind the surviving one
            2'b11: begin
               if (occ == 2'd1) head <= din;
               else begin
                  head <= tail;
                  tail <= din;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/dtw_core_ref_dump.sv
// Reference-memory readback: streams words 0..len-1 into the destination
// FIFO in address order, at most two words outstanding at any time.
module dtw_core_ref_dump
   import dtw_core_pkg::*;
#(
   parameter int DATA_WIDTH       = 16,
   parameter int REFMEM_PTR_WIDTH = 20
) (
   input  logic                        clk_in,
   input  logic                        rst_in,
   input  logic                        rs_in,
   input  logic [REFMEM_PTR_WIDTH-1:0] ref_len_in,
   output logic                        busy_out,
   output logic                        dump_done_out,
   output logic [REFMEM_PTR_WIDTH-1:0] ref_addr_out,
   input  logic [DATA_WIDTH-1:0]       ref_data_in,
   output logic                        dst_fifo_clear_out,
   output logic                        dst_fifo_wren_out,
   input  logic                        dst_fifo_full_in,
   output logic [DATA_WIDTH-1:0]       dst_fifo_data_out,
   output logic [1:0]                  dbg_state,
   output logic [REFMEM_PTR_WIDTH-1:0] dbg_addr
);

   localparam int PW = REFMEM_PTR_WIDTH;

   logic [1:0]    state, state_nxt;
   logic [PW-1:0] len, iss, wr, addr_q;
   logic          inflight, issue, wren, flush;
   logic [1:0]    occ, pending;

   assign pending = {1'b0, inflight} + occ;
   assign wren    = (state == DUMP) && (occ != 2'd0) && !dst_fifo_full_in;
   // a write this cycle frees a slot, so a full pipe can still issue
   assign issue   = (state == DUMP) && (iss < len) &&
                    ((pending < 2'd2) || ((pending == 2'd2) && wren));
   assign flush   = rst_in || (state_nxt == IDLE);

   always_ff @(posedge clk_in) begin
      if (rst_in) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (rs_in) state_nxt = DUMP;
         DUMP: begin
            if (!rs_in)                      state_nxt = IDLE;
            else if (wr + PW'(wren) == len)  state_nxt = DONE;
         end
         DONE: if (!rs_in) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy_out           = (state == DUMP);
      dump_done_out      = (state == DONE);
      dst_fifo_clear_out = (state == IDLE);
   end

   // pointers are zeroed whenever the next cycle is IDLE (reset or abort)
   always_ff @(posedge clk_in) begin
      if (flush) begin
         len      <= '0;
         iss      <= '0;
         wr       <= '0;
         addr_q   <= '0;
         inflight <= 1'b0;
      end else begin
         if (state == IDLE) len <= ref_len_in;
         if (issue) begin
            iss    <= iss + 1'b1;
            addr_q <= iss;
         end
         if (wren) wr <= wr + 1'b1;
         inflight <= issue;
      end
   end

   dtw_core_ref_skid #(.W(DATA_WIDTH)) u_skid (
      .clk   (clk_in),
      .clear (flush),
      .push  (inflight),
      .pop   (wren),
      .din   (ref_data_in),
      .head  (dst_fifo_data_out),
      .occ   (occ)
   );

   assign ref_addr_out      = issue ? iss : addr_q;
   assign dst_fifo_wren_out = wren;
   assign dbg_state         = state;
   assign dbg_addr          = iss;

endmodule

// File: tb/tb_dtw_core_ref_dump.sv
// Directed bench for the reference readback engine with a scoreboard
// queue fed by the stimulus and drained by a write monitor.
module tb_dtw_core_ref_dump;

   localparam int DW = 16;
   localparam int PW = 20;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          rs = 1'b0;
   logic [PW-1:0] ref_len = '0;
   logic          busy, done, clr, wren;
   logic          full = 1'b0;
   logic [PW-1:0] ref_addr, dbg_addr;
   logic [DW-1:0] ref_data = '0;
   logic [DW-1:0] fifo_data;
   logic [1:0]    dbg_state;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;

   logic [DW-1:0] exp_q[$];

   // monitor-owned per-run statistics, cleared whenever run_id changes
   int run_id = 0;
   int mon_run = 0;
   int wr_cnt = 0, busy_cnt = 0;
   int e_cyc = 0, done_cyc = 0, first_wr = 0, last_wr = 0;
   bit e_seen = 0, done_seen = 0, pend_bad = 0;

   dtw_core_ref_dump #(.DATA_WIDTH(DW), .REFMEM_PTR_WIDTH(PW)) dut (
      .clk_in             (clk),
      .rst_in             (rst),
      .rs_in              (rs),
      .ref_len_in         (ref_len),
      .busy_out           (busy),
      .dump_done_out      (done),
      .ref_addr_out       (ref_addr),
      .ref_data_in        (ref_data),
      .dst_fifo_clear_out (clr),
      .dst_fifo_wren_out  (wren),
      .dst_fifo_full_in   (full),
      .dst_fifo_data_out  (fifo_data),
      .dbg_state          (dbg_state),
      .dbg_addr           (dbg_addr)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // reference memory preloaded with 0x1000+i, one-cycle read latency
   always @(posedge clk) ref_data <= 16'h1000 + ref_addr[15:0];

   always @(negedge clk) begin
      logic [DW-1:0] e;
      if (run_id != mon_run) begin
         mon_run = run_id;
         wr_cnt = 0; busy_cnt = 0; e_seen = 0; done_seen = 0; pend_bad = 0;
      end
      if (busy) begin
         busy_cnt++;
         if (!e_seen) begin e_seen = 1; e_cyc = cyc; end
      end
      if (done && !done_seen) begin done_seen = 1; done_cyc = cyc; end
      if (dut.pending > 2'd2) pend_bad = 1;
      if (wren) begin
         n_chk++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_write: got data %h, expected no write (cycle %0d)", fifo_data, cyc);
         end else begin
            e = exp_q.pop_front();
            if (fifo_data !== e) begin
               n_fail++;
               $display("FAIL write_data: got %h, expected %h (cycle %0d)", fifo_data, e, cyc);
            end
         end
         if (wr_cnt == 0) first_wr = cyc;
         last_wr = cyc;
         wr_cnt++;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic drive_edge();
      @(posedge clk); #1;
   endtask

   task automatic sample();
      @(negedge clk); #1;
   endtask

   task automatic push_words(input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(16'h1000 + 16'(i));
   endtask

   task automatic wait_done(input string name, input int lim);
      for (int i = 0; i < lim && !done; i++) sample();
      check(name, {31'd0, done}, 32'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_state"}, {30'd0, dbg_state}, 32'd0);
      check({tag, "_busy_done_clr_wren"}, {28'd0, busy, done, clr, wren}, 32'b0010);
      check({tag, "_addr"}, {12'd0, ref_addr}, 32'd0);
      check({tag, "_dbg_addr"}, {12'd0, dbg_addr}, 32'd0);
      check({tag, "_data"}, {16'd0, fifo_data}, 32'd0);
   endtask

   initial begin
      // reset and idle
      repeat (3) drive_edge();
      rst = 1'b0;
      sample();
      check_reset_outputs("reset");
      sample();
      check_reset_outputs("idle");

      // len=8, no backpressure: exact cycle timing
      run_id++;
      push_words(8);
      drive_edge();
      ref_len = 20'd8; rs = 1'b1;
      wait_done("len8_done", 100);
      check("len8_count", wr_cnt, 8);
      check("len8_first_wr", first_wr, e_cyc + 2);
      check("len8_last_wr", last_wr, e_cyc + 9);
      check("len8_done_cyc", done_cyc, e_cyc + 10);
      check("len8_busy_in_done", {31'd0, busy}, 32'd0);
      check("len8_q_empty", exp_q.size(), 0);
      drive_edge(); rs = 1'b0;
      sample(); sample();
      check("len8_back_idle", {30'd0, dbg_state}, 32'd0);

      // len=16 under pseudo-random backpressure
      run_id++;
      push_words(16);
      drive_edge();
      ref_len = 20'd16; rs = 1'b1;
      for (int i = 0; i < 400 && !done; i++) begin
         drive_edge();
         full = 1'($urandom_range(0, 1));
      end
      full = 1'b0;
      sample();
      check("len16_done", {31'd0, done}, 32'd1);
      check("len16_count", wr_cnt, 16);
      check("len16_pending_le2", {31'd0, pend_bad}, 32'd0);
      check("len16_q_empty", exp_q.size(), 0);
      drive_edge(); rs = 1'b0;
      sample(); sample();

      // len=0: single DUMP cycle, no writes
      run_id++;
      drive_edge();
      ref_len = 20'd0; rs = 1'b1;
      wait_done("len0_done", 20);
      check("len0_done_cyc", done_cyc, e_cyc + 1);
      check("len0_busy_cycles", busy_cnt, 1);
      check("len0_count", wr_cnt, 0);
      drive_edge(); rs = 1'b0;
      sample(); sample();
      check("len0_back_idle", {30'd0, dbg_state}, 32'd0);
      check("len0_clear", {31'd0, clr}, 32'd1);

      // len=100, full from E+3 (one write at E+2), abort at cycle 20
      run_id++;
      push_words(1);
      drive_edge();
      ref_len = 20'd100; rs = 1'b1;
      repeat (4) drive_edge();
      full = 1'b1;
      repeat (16) drive_edge();
      rs = 1'b0;
      sample(); sample();
      check("abort_idle", {30'd0, dbg_state}, 32'd0);
      check("abort_addr", {12'd0, ref_addr}, 32'd0);
      drive_edge(); full = 1'b0;
      repeat (6) sample();
      check("abort_count", wr_cnt, 1);
      check("abort_no_done", {31'd0, done_seen}, 32'd0);
      check("abort_q_empty", exp_q.size(), 0);

      // second run after abort
      run_id++;
      push_words(4);
      drive_edge();
      ref_len = 20'd4; rs = 1'b1;
      wait_done("rerun_done", 50);
      check("rerun_count", wr_cnt, 4);
      check("rerun_q_empty", exp_q.size(), 0);
      drive_edge(); rs = 1'b0;
      sample(); sample();

      // synchronous reset after the fifth of ten words
      run_id++;
      push_words(5);
      drive_edge();
      ref_len = 20'd10; rs = 1'b1;
      for (int i = 0; i < 100 && wr_cnt < 5; i++) sample();
      check("rst_reached_5", wr_cnt, 5);
      rst = 1'b1;
      sample();
      check_reset_outputs("midrst");
      drive_edge();
      rst = 1'b0; rs = 1'b0;
      repeat (6) sample();
      check("midrst_count", wr_cnt, 5);
      check("midrst_q_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/dtw_core_ref_dump.md
# dtw_core_ref_dump

Reference-memory readback engine for the DTW core. It streams the first `ref_len_in` words of the reference memory (addresses 0 .. ref_len_in-1) into a destination FIFO, so the host can verify a loaded reference over the same AXI-Stream/DMA path used to load it. It drives the reference memory's read-only port (one-cycle read latency), absorbs destination-FIFO backpressure in a 2-entry skid buffer, and follows the core's rs/busy run-control convention.

## Interface
Parameters:
- DATA_WIDTH, 16, reference sample width
- REFMEM_PTR_WIDTH, 20, reference memory address width

Ports:
- clk_in  in  1  single clock
- rst_in  in  1  reset; synchronous, active-high
- rs_in  in  1  run (1) / stop (0), level-sensitive
- ref_len_in  in  REFMEM_PTR_WIDTH  number of words to dump; sampled on entry to DUMP
- busy_out  out  1  high in DUMP
- dump_done_out  out  1  high in DONE
- ref_addr_out  out  REFMEM_PTR_WIDTH  reference memory read address
- ref_data_in  in  DATA_WIDTH  read data, valid one cycle after the address is issued
- dst_fifo_clear_out  out  1  high in IDLE
- dst_fifo_wren_out  out  1  destination FIFO write enable
- dst_fifo_full_in  in  1  destination FIFO full
- dst_fifo_data_out  out  DATA_WIDTH  destination FIFO write data
- dbg_state  out  2  current FSM state
- dbg_addr  out  REFMEM_PTR_WIDTH  issue pointer

## Operation
- States:
  - IDLE=0: clear asserted; all pointers and counters zeroed.
  - DUMP=1.
  - DONE=2.
- IDLE -> DUMP: when rs_in=1. Latch len = ref_len_in; issue pointer `iss` = 0; written count `wr` = 0.
- DUMP issue rule: issue a read when both hold:
  - iss < len
  - pending < 2, or pending == 2 and a FIFO write occurs this cycle
  
  `pending` = words in flight plus words in the skid buffer. Issuing presents `ref_addr_out = iss` and increments iss.
- Capture: a word issued in cycle t is captured from ref_data_in into the skid buffer at the end of t+1.
- Write: dst_fifo_wren_out = (skid occupancy != 0) && !dst_fifo_full_in. This is a combinational path from full. dst_fifo_data_out is the skid head and is a registered value. Each write increments wr and pops the skid buffer.
- DUMP -> DONE: when wr == len, including a write in the current cycle. With len == 0, DUMP exits after exactly one cycle with zero writes.
- DONE -> IDLE: when rs_in=0. DONE holds while rs_in=1; no re-trigger.
- rs_in=0 while in DUMP: abort to IDLE next cycle. The in-flight word is discarded, the skid buffer is flushed, no further writes occur, and dump_done_out is never asserted.
- Order: words are written strictly in address order. No word is dropped or duplicated under any full pattern.
- Address hold: ref_addr_out holds its last issued value when not issuing, and is 0 in IDLE.

## Timing
- Reset values:
  - all outputs 0, except dst_fifo_clear_out = 1
  - state IDLE
  - skid buffer empty
- Startup: let E = the first DUMP cycle. Address 0 is issued in E, data is captured at the end of E+1, and the first wren is in E+2 (if not full).
- Throughput: one word per cycle with full low. The last write is in cycle E+len+1; DONE is entered at E+len+2.
- Backpressure:
  - full asserting stops writes the same cycle; at most 2 words are buffered and issue stalls.
  - full deasserting resumes writes the same cycle; issue resumes in that cycle via the pending==2 rule.
- Simultaneous capture and pop in one cycle: occupancy is unchanged and the head advances.
- Width: iss, wr and len are REFMEM_PTR_WIDTH unsigned. Comparisons are unsigned; iss never exceeds len, so there is no wrap.
- rst_in mid-DUMP: the next cycle is IDLE with reset values, regardless of rs_in.

## Structure
- Shared package `dtw_core_pkg`:
  - state localparams IDLE/DUMP/DONE (2-bit)
  - MODE_DTW_READ / MODE_LOAD_REF, shared with the loader
- Sub-module `dtw_core_ref_skid`: 2-entry FIFO with push/pop/occupancy, registered head, and synchronous clear.
- The top level contains the FSM, the iss/wr/pending counters, and the issue/write logic.

## Test plan
- Reset, then idle: all outputs 0, clear=1, dbg_state=0.
- ref_len_in=8, memory preloaded with 0x1000+i, full tied low, rs_in=1: exactly 8 writes in cycles E+2..E+9 with data 0x1000..0x1007; dump_done_out high from E+10; busy low in DONE.
- ref_len_in=16, full toggling pseudo-randomly (50%): exactly 16 writes, data in order 0x1000..0x100F; pending never exceeds 2.
- ref_len_in=0, rs_in=1: one DUMP cycle, zero writes, then DONE; dropping rs_in returns to IDLE.
- ref_len_in=100, full held high from the third cycle, rs_in dropped at cycle 20: no writes after abort; IDLE next cycle; done never asserted; a second run with ref_len_in=4 outputs 0x1000..0x1003.
- rst_in asserted at word 5 of 10: IDLE next cycle with all outputs at reset values; no further wren.
